// File: rtl/threshold_frame_ctrl.sv
// threshold_frame_ctrl: loads a pixel frame, waits for the threshold datapath to settle, captures and streams its binary result
module threshold_frame_ctrl #(
    parameter int WIDTH = 10,
    parameter int HEIGHT = 10,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [7:0]                    in_data,
    output logic [0:8*WIDTH*HEIGHT-1]     frame_out,
    input  logic [0:8*WIDTH*HEIGHT-1]     result_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_data,
    output logic                          out_last,
    output logic                          busy,
    output logic                          frame_done
);
    localparam int N = WIDTH * HEIGHT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [7:0] SETTLE_LAST = 8'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    typedef enum logic [2:0] {IDLE, LOAD, SETTLE, CAPTURE, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   pix_cnt_q, pix_cnt_d;
    logic [7:0]      settle_cnt_q, settle_cnt_d;
    logic [0:8*N-1]  frame_q, frame_d;
    logic [0:8*N-1]  result_q, result_d;
    logic            frame_done_q, frame_done_d;
    logic [CW+2:0]   bit_idx;
    logic            in_fire;
    logic            out_fire;

    // Byte p of the packed frame starts at bit 8p, LSB first
    assign bit_idx    = {pix_cnt_q, 3'b000};
    assign in_ready   = rst_n && (state_q == IDLE || state_q == LOAD);
    assign out_valid  = state_q == DRAIN;
    assign out_data   = out_valid && result_q[bit_idx];
    assign out_last   = out_valid && pix_cnt_q == LAST;
    assign busy       = state_q != IDLE;
    assign frame_done = frame_done_q;
    assign frame_out  = frame_q;
    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;

    // Next-state, counter and frame/result register updates
    always_comb begin
        state_d      = state_q;
        pix_cnt_d    = pix_cnt_q;
        settle_cnt_d = settle_cnt_q;
        frame_d      = frame_q;
        result_d     = result_q;
        frame_done_d = 1'b0;
        if (in_fire) begin
            frame_d[bit_idx +: 8] = {<<{in_data}};
            pix_cnt_d = pix_cnt_q + 1'b1;
            state_d   = LOAD;
            if (pix_cnt_q == LAST) begin
                pix_cnt_d    = '0;
                settle_cnt_d = '0;
                state_d      = (SETTLE_CYCLES == 0) ? CAPTURE : SETTLE;
            end
        end
        if (state_q == SETTLE) begin
            settle_cnt_d = settle_cnt_q + 8'd1;
            state_d      = (settle_cnt_q == SETTLE_LAST) ? CAPTURE : SETTLE;
        end
        if (state_q == CAPTURE) begin
            result_d = result_in;
            state_d  = DRAIN;
        end
        if (out_fire) begin
            pix_cnt_d = pix_cnt_q + 1'b1;
            if (pix_cnt_q == LAST) begin
                pix_cnt_d    = '0;
                state_d      = IDLE;
                frame_done_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pix_cnt_q    <= '0;
            settle_cnt_q <= '0;
            frame_q      <= '0;
            result_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_cnt_q    <= pix_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            frame_q      <= frame_d;
            result_q     <= result_d;
            frame_done_q <= frame_done_d;
        end
    end
endmodule

// File: tb/tb_threshold_frame_ctrl.sv
// tb_threshold_frame_ctrl: directed checks of load, settle/capture timing, drain, backpressure and reset
module tb_threshold_frame_ctrl;
    localparam int FB = 72;
    localparam logic [8:0] M1 = 9'h155;
    localparam logic [8:0] M2 = 9'h0B3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]          rst_n, in_valid, in_ready, out_valid, out_ready, out_data, out_last, busy, frame_done;
    logic [1:0][7:0]     in_data;
    logic [1:0][0:FB-1]  frame_out, result_in;
    int tests = 0;
    int fails = 0;
    int cyc;

    threshold_frame_ctrl #(.WIDTH(3), .HEIGHT(3), .SETTLE_CYCLES(2)) u0 (
        .clk(clk), .rst_n(rst_n[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .frame_out(frame_out[0]), .result_in(result_in[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .out_last(out_last[0]), .busy(busy[0]), .frame_done(frame_done[0])
    );

    threshold_frame_ctrl #(.WIDTH(3), .HEIGHT(3), .SETTLE_CYCLES(0)) u1 (
        .clk(clk), .rst_n(rst_n[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .frame_out(frame_out[1]), .result_in(result_in[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .out_last(out_last[1]), .busy(busy[1]), .frame_done(frame_done[1])
    );

    function automatic logic [7:0] byte_of(input logic [0:FB-1] f, input int p);
        logic [7:0] b;
        for (int k = 0; k < 8; k++) b[k] = f[8*p+k];
        return b;
    endfunction

    function automatic logic [0:FB-1] res_of(input logic [8:0] m);
        logic [0:FB-1] r;
        for (int p = 0; p < 9; p++)
            for (int k = 0; k < 8; k++) r[8*p+k] = m[p];
        return r;
    endfunction

    task automatic load(input int d, input logic [7:0] base, input int p0, input bit gaps, output int n_cyc);
        int p;
        bit tog;
        p = p0;
        tog = 1'b0;
        n_cyc = 0;
        while (p < 9 && n_cyc < 100) begin
            @(negedge clk);
            n_cyc++;
            tog = gaps ? !tog : 1'b1;
            in_valid[d] = tog;
            in_data[d] = base + 8'(p);
            if (tog && in_ready[d]) p++;
        end
        tests++;
        if (p != 9) begin
            fails++;
            $display("FAIL load_count dut%0d: accepted up to %0d, required 9", d, p);
        end
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
    endtask

    task automatic check_frame(input int d, input logic [7:0] base, input string name);
        for (int p = 0; p < 9; p++) begin
            tests++;
            if (byte_of(frame_out[d], p) !== base + 8'(p)) begin
                fails++;
                $display("FAIL %s byte %0d: got %h, required %h", name, p, byte_of(frame_out[d], p), base + 8'(p));
            end
        end
    endtask

    // Presents the real result only in the cycle before the expected capture edge
    task automatic capture(input int d, input int s, input logic [8:0] m);
        result_in[d] = ~res_of(m);
        repeat (s) @(posedge clk);
        #1;
        tests++;
        if (out_valid[d] !== 1'b0) begin
            fails++;
            $display("FAIL pre_capture dut%0d: out_valid %b, required 0", d, out_valid[d]);
        end
        result_in[d] = res_of(m);
        @(posedge clk);
        #1;
        result_in[d] = ~res_of(m);
        tests++;
        if (out_valid[d] !== 1'b1) begin
            fails++;
            $display("FAIL capture_edge dut%0d: out_valid %b, required 1", d, out_valid[d]);
        end
    endtask

    task automatic drain(input int d, input logic [8:0] m, input int stall_at, input int stall_len,
                         input int n, input bit bb_en, input logic [7:0] bb);
        int got;
        int st;
        int c;
        logic stall;
        got = 0;
        st = 0;
        c = 0;
        while (got < n && c < 200) begin
            @(negedge clk);
            c++;
            stall = (got == stall_at && st < stall_len);
            out_ready[d] = !stall;
            tests++;
            if ({out_valid[d], out_data[d], out_last[d], frame_done[d]} !== {1'b1, m[got], got == 8, 1'b0}) begin
                fails++;
                $display("FAIL drain_pixel dut%0d px %0d: valid/data/last/done %b%b%b%b, required 1%b%b0",
                         d, got, out_valid[d], out_data[d], out_last[d], frame_done[d], m[got], got == 8);
            end
            if (stall) st++;
            else got++;
        end
        out_ready[d] = 1'b1;
        tests++;
        if (got != n) begin
            fails++;
            $display("FAIL drain_count dut%0d: delivered %0d, required %0d", d, got, n);
        end
        if (n == 9) begin
            @(negedge clk);
            tests++;
            if ({frame_done[d], out_valid[d], busy[d], in_ready[d]} !== 4'b1001) begin
                fails++;
                $display("FAIL frame_done dut%0d: done/valid/busy/ready %b%b%b%b, required 1001",
                         d, frame_done[d], out_valid[d], busy[d], in_ready[d]);
            end
            if (bb_en) begin
                in_valid[d] = 1'b1;
                in_data[d] = bb;
            end
            @(negedge clk);
            in_valid[d] = 1'b0;
            tests++;
            if (frame_done[d] !== 1'b0) begin
                fails++;
                $display("FAIL frame_done_pulse dut%0d: got %b, required 0", d, frame_done[d]);
            end
        end
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if (in_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: in_ready %b busy %b, required 1 0", in_ready[0], busy[0]);
        end
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_data[0] = 8'h55;
        repeat (3) @(posedge clk);
        #3;
        tests++;
        if (busy[0] !== 1'b1) begin
            fails++;
            $display("FAIL reset_preload_busy: got %b, required 1", busy[0]);
        end
        rst_n[0] = 1'b0;
        #1;
        tests++;
        if ({in_ready[0], busy[0], out_valid[0], out_data[0], out_last[0], frame_done[0]} !== 6'b0 || frame_out[0] !== '0) begin
            fails++;
            $display("FAIL async_reset: ready/busy/valid/data/last/done %b%b%b%b%b%b frame %h, required all zero",
                     in_ready[0], busy[0], out_valid[0], out_data[0], out_last[0], frame_done[0], frame_out[0]);
        end
        @(posedge clk);
        #1;
        tests++;
        if (in_ready[0] !== 1'b0 || frame_out[0] !== '0) begin
            fails++;
            $display("FAIL reset_hold: in_ready %b frame %h, required 0 and zero", in_ready[0], frame_out[0]);
        end
        @(negedge clk);
        in_valid[0] = 1'b0;
        rst_n[0] = 1'b1;
        #1;
        tests++;
        if (in_ready[0] !== 1'b1) begin
            fails++;
            $display("FAIL reset_release2: in_ready %b, required 1", in_ready[0]);
        end
    endtask

    task automatic test_full_rate();
        load(0, 8'h10, 0, 1'b0, cyc);
        tests++;
        if (cyc != 9) begin
            fails++;
            $display("FAIL full_rate_cycles: got %0d, required 9", cyc);
        end
        check_frame(0, 8'h10, "full_rate_frame");
        capture(0, 2, M1);
        drain(0, M1, 99, 0, 9, 1'b0, 8'h00);
    endtask

    task automatic test_backpressure();
        load(0, 8'h20, 0, 1'b0, cyc);
        check_frame(0, 8'h20, "bp_frame");
        capture(0, 2, M2);
        drain(0, M2, 4, 5, 9, 1'b0, 8'h00);
    endtask

    task automatic test_input_gaps();
        load(0, 8'h10, 0, 1'b1, cyc);
        tests++;
        if (cyc != 17) begin
            fails++;
            $display("FAIL gap_cycles: got %0d, required 17", cyc);
        end
        check_frame(0, 8'h10, "gap_frame");
        capture(0, 2, M1);
        drain(0, M1, 99, 0, 9, 1'b0, 8'h00);
    endtask

    task automatic test_reset_drain();
        load(0, 8'h40, 0, 1'b0, cyc);
        capture(0, 2, M1);
        drain(0, M1, 99, 0, 4, 1'b0, 8'h00);
        @(posedge clk);
        #3;
        rst_n[0] = 1'b0;
        #1;
        tests++;
        if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
            fails++;
            $display("FAIL drain_reset: out_valid %b busy %b, required 0 0", out_valid[0], busy[0]);
        end
        repeat (2) begin
            @(negedge clk);
            tests++;
            if (frame_done[0] !== 1'b0) begin
                fails++;
                $display("FAIL drain_reset_done: got %b, required 0", frame_done[0]);
            end
        end
        rst_n[0] = 1'b1;
        load(0, 8'h50, 0, 1'b0, cyc);
        check_frame(0, 8'h50, "post_reset_frame");
        capture(0, 2, M2);
        drain(0, M2, 99, 0, 9, 1'b0, 8'h00);
    endtask

    task automatic test_back_to_back();
        load(1, 8'h10, 0, 1'b0, cyc);
        check_frame(1, 8'h10, "b2b_frame_a");
        capture(1, 0, M1);
        drain(1, M1, 99, 0, 9, 1'b1, 8'hA0);
        tests++;
        if (byte_of(frame_out[1], 0) !== 8'hA0 || busy[1] !== 1'b1) begin
            fails++;
            $display("FAIL b2b_first: byte0 %h busy %b, required a0 1", byte_of(frame_out[1], 0), busy[1]);
        end
        for (int p = 1; p < 9; p++) begin
            tests++;
            if (byte_of(frame_out[1], p) !== 8'h10 + 8'(p)) begin
                fails++;
                $display("FAIL b2b_old byte %0d: got %h, required %h", p, byte_of(frame_out[1], p), 8'h10 + 8'(p));
            end
        end
        load(1, 8'hA0, 1, 1'b0, cyc);
        check_frame(1, 8'hA0, "b2b_frame_b");
        capture(1, 0, M2);
        drain(1, M2, 99, 0, 9, 1'b0, 8'h00);
    endtask

    initial begin
        rst_n = 2'b00;
        in_valid = 2'b00;
        in_data = '0;
        out_ready = 2'b11;
        result_in = '0;
        #1;
        tests++;
        if (in_ready !== 2'b00 || out_valid !== 2'b00 || busy !== 2'b00) begin
            fails++;
            $display("FAIL initial_reset: in_ready %b out_valid %b busy %b, required 00", in_ready, out_valid, busy);
        end
        repeat (2) @(negedge clk);
        rst_n = 2'b11;
        test_reset();
        test_full_rate();
        test_backpressure();
        test_input_gaps();
        test_reset_drain();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
